// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   rx_state_e        receive FSM state encoding (also visible on the debug port)
//   WLS_*             word-length select codes (data bits = code + 5)
//   OS_A_DEF/OS_B_DEF default oversample ratios
//   parity_expected() parity bit a transmitter sends / a receiver expects
//   majority3()       2-of-3 vote used by the receive sampler
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_STOP2    = 3'd5,
    ST_BRK_WAIT = 3'd6
  } rx_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam int OS_A_DEF  = 16;
  localparam int OS_B_DEF  = 13;
  localparam int PAR_WIDTH = 8;

  // Data above the word length is zero, so reducing over all 8 bits is
  // the same as reducing over the active word.
  // eps=1 (even): total ones including parity is even -> bit = ^data.
  // sp=1 (stick): the bit is the constant ~eps.
  function automatic logic parity_expected(input logic [PAR_WIDTH-1:0] data,
                                           input logic eps,
                                           input logic sp);
    logic p;
    if (sp) p = ~eps;
    else    p = eps ? (^data) : (~^data);
    return p;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: input synchroniser and 3-sample majority voter.
//   clk, rst    system clock, synchronous active-high reset
//   rx_i        asynchronous serial input (idle high)
//   sample_en   capture the synchronised line as one of the first two votes
//   rx_sync     synchronised line level
//   bit_val     majority of the two captured votes and the current rx_sync;
//               valid on the cycle that carries the third sample point
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  input  logic sample_en,
  output logic rx_sync,
  output logic bit_val
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             smp_q;

  // The synchroniser runs every clock so that the line is settled well
  // before the next oversample tick; only the vote register is tick-gated.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      smp_q  <= 2'b11;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      if (sample_en) smp_q <= {smp_q[0], rx_sync};
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];
  assign bit_val = majority3(smp_q[1], smp_q[0], rx_sync);

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receive engine (5..8 data bits, optional
// odd/even/stick parity, 1 or 2 stop bits, break and false-start detection).
//   clk, rst      system clock, synchronous active-high reset
//   baud_en       one-clock oversample tick from the baud generator
//   rx_i          asynchronous serial input, idle high
//   wls,pen,eps,sp,stb,osm_sel   frame format, latched at start detect
//   rx_data       received word, zero-extended above the word length
//   rx_valid      one-clock pulse: rx_data/pe/fe/bi updated
//   pe, fe, bi    parity error, framing error, break indication
//   rx_busy       high whenever the FSM is not idle
//   state_dbg     current FSM state
//
// Output handshake: rx_valid is a valid-only strobe with no ready/backpressure.
// It is high for exactly one clock, the clock after the tick that takes the
// first stop-bit vote; rx_data/pe/fe/bi change only on that same edge and
// hold until the next frame is published, so a consumer may sample them on
// the rx_valid cycle or any time afterwards.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,   // must be >= 8 (word length is up to 8)
  parameter int SYNC_STAGES = 2,
  parameter int OS_A        = OS_A_DEF,
  parameter int OS_B        = OS_B_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_en,
  input  logic              rx_i,
  input  logic [1:0]        wls,
  input  logic              pen,
  input  logic              eps,
  input  logic              sp,
  input  logic              stb,
  input  logic              osm_sel,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              pe,
  output logic              fe,
  output logic              bi,
  output logic              rx_busy,
  output rx_state_e         state_dbg
);

  localparam int OS_MAX = (OS_A > OS_B) ? OS_A : OS_B;
  localparam int TCW    = $clog2(OS_MAX);
  localparam int BCW    = $clog2(DATA_W);

  rx_state_e st_q, st_d;

  logic [TCW-1:0]    tc_q;
  logic [BCW-1:0]    bit_cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              par_q;
  logic              pe_q;

  logic [1:0] cfg_wls;
  logic       cfg_pen, cfg_eps, cfg_sp, cfg_stb, cfg_osm;

  logic           rx_sync, bit_val, sample_en;
  logic [TCW-1:0] tc_last, tc_lo, tc_mid, tc_hi;
  logic [BCW-1:0] last_bit;
  logic           at_dec, at_end, stop_bi;

  // Per-frame timing from the latched oversample select.
  assign tc_last  = cfg_osm ? TCW'(OS_B - 1)     : TCW'(OS_A - 1);
  assign tc_lo    = cfg_osm ? TCW'(OS_B / 2 - 1) : TCW'(OS_A / 2 - 1);
  assign tc_mid   = cfg_osm ? TCW'(OS_B / 2)     : TCW'(OS_A / 2);
  assign tc_hi    = cfg_osm ? TCW'(OS_B / 2 + 1) : TCW'(OS_A / 2 + 1);
  assign last_bit = BCW'(cfg_wls) + BCW'(4);

  assign at_dec  = (tc_q == tc_hi);
  assign at_end  = (tc_q == tc_last);
  // Break: every data bit, the parity bit (0 when disabled) and the stop vote low.
  assign stop_bi = (data_q == '0) && !par_q && !bit_val;

  assign sample_en = baud_en && ((tc_q == tc_lo) || (tc_q == tc_mid)) &&
                     (st_q != ST_IDLE) && (st_q != ST_BRK_WAIT);

  uart_rx_sampler #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx_i     (rx_i),
    .sample_en(sample_en),
    .rx_sync  (rx_sync),
    .bit_val  (bit_val)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  // FSM next state.
  always_comb begin
    st_d = st_q;
    if (baud_en) begin
      case (st_q)
        ST_IDLE:     if (!rx_sync) st_d = ST_START;
        ST_START: begin
          if (at_dec && bit_val) st_d = ST_IDLE;   // false start
          else if (at_end)       st_d = ST_DATA;
        end
        ST_DATA:     if (at_end && (bit_cnt_q == last_bit))
                       st_d = cfg_pen ? ST_PARITY : ST_STOP;
        ST_PARITY:   if (at_end) st_d = ST_STOP;
        ST_STOP:     if (at_dec)
                       st_d = stop_bi ? ST_BRK_WAIT : (cfg_stb ? ST_STOP2 : ST_IDLE);
        // bit_cnt_q is 0 through the rest of the first stop bit and 1
        // during the second; leave at the end of the second.
        ST_STOP2:    if (at_end && (bit_cnt_q != '0)) st_d = ST_IDLE;
        ST_BRK_WAIT: if (rx_sync) st_d = ST_IDLE;
        default:     st_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    rx_busy   = (st_q != ST_IDLE);
    state_dbg = st_q;
  end

  // Counters, shift register, error capture and published outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q      <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
      cfg_wls   <= 2'b00;
      cfg_pen   <= 1'b0;
      cfg_eps   <= 1'b0;
      cfg_sp    <= 1'b0;
      cfg_stb   <= 1'b0;
      cfg_osm   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      pe        <= 1'b0;
      fe        <= 1'b0;
      bi        <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (baud_en) begin
        case (st_q)
          ST_IDLE: if (!rx_sync) begin
            cfg_wls   <= wls;
            cfg_pen   <= pen;
            cfg_eps   <= eps;
            cfg_sp    <= sp;
            cfg_stb   <= stb;
            cfg_osm   <= osm_sel;
            // The detect tick is itself tick 0 of the start bit.
            tc_q      <= TCW'(1);
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            pe_q      <= 1'b0;
          end
          ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_STOP2:
            tc_q <= at_end ? '0 : tc_q + TCW'(1);
          default: tc_q <= '0;
        endcase

        if (st_q == ST_DATA) begin
          if (at_dec) data_q[bit_cnt_q] <= bit_val;
          if (at_end) bit_cnt_q <= (bit_cnt_q == last_bit) ? '0 : bit_cnt_q + BCW'(1);
        end

        if ((st_q == ST_PARITY) && at_dec) begin
          par_q <= bit_val;
          pe_q  <= bit_val ^ parity_expected(data_q[PAR_WIDTH-1:0], cfg_eps, cfg_sp);
        end

        if ((st_q == ST_STOP) && at_dec) begin
          rx_data  <= data_q;
          pe       <= pe_q;
          fe       <= ~bit_val;
          bi       <= stop_bi;
          rx_valid <= 1'b1;
        end

        if ((st_q == ST_STOP2) && at_end) bit_cnt_q <= bit_cnt_q + BCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame. A baud tick is issued
// every 4th clock; serial bits are driven right after a tick so the
// synchroniser has settled before the next one. Expected frames are queued
// when a frame is sent and popped whenever the DUT pulses rx_valid.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int W = 11;  // {bi, fe, pe, rx_data[7:0]}

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_en;
  logic       rx_i;
  logic [1:0] wls;
  logic       pen, eps, sp, stb, osm_sel;
  logic [7:0] rx_data;
  logic       rx_valid, pe, fe, bi, rx_busy;
  rx_state_e  state_dbg;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int tick_no = 0;
  int frame_t0 = 0;
  int last_valid_tick = -1;
  logic last_valid_on_tick = 1'b0;

  uart_rx_frame dut (
    .clk      (clk),
    .rst      (rst),
    .baud_en  (baud_en),
    .rx_i     (rx_i),
    .wls      (wls),
    .pen      (pen),
    .eps      (eps),
    .sp       (sp),
    .stb      (stb),
    .osm_sel  (osm_sel),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .pe       (pe),
    .fe       (fe),
    .bi       (bi),
    .rx_busy  (rx_busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic e_pe, input logic e_fe,
                              input logic e_bi);
    exp_q.push_back({e_bi, e_fe, e_pe, d});
  endtask

  // Parity error as the receiver should report it, from first principles.
  function automatic logic model_pe(input logic [7:0] d, input int nbits, input logic e_eps,
                                    input logic e_sp, input logic par_bit);
    int ones;
    logic want;
    ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(d[i]);
    if (e_sp)       want = ~e_eps;
    else if (e_eps) want = (ones % 2 == 1);
    else            want = (ones % 2 == 0);
    return par_bit != want;
  endfunction

  // ---------------- drivers ----------------
  // One clock; every clock is scanned for rx_valid and scored.
  task automatic clk_step(input logic be);
    logic [W-1:0] e;
    baud_en = be;
    @(posedge clk);
    #1;
    baud_en = 1'b0;
    if (be) tick_no++;
    if (rx_valid === 1'b1) begin
      last_valid_tick    = tick_no;
      last_valid_on_tick = be;
      check("rx_valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("frame {bi,fe,pe,data}", 32'({bi, fe, pe, rx_data}), 32'(e));
      end
    end
  endtask

  task automatic tick();
    repeat (3) clk_step(1'b0);
    clk_step(1'b1);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) tick();
  endtask

  // Drives start, data (LSB first), optional parity and stop bits, os ticks
  // each. Tick offsets (0 = start-detect tick) can inject a 1-tick glitch,
  // change wls mid-frame, or pulse rst and abandon the frame.
  task automatic send_frame(input logic [7:0] d, input int nbits, input int os,
                            input bit has_par, input logic par_bit, input logic stop1,
                            input int nstop, input int glitch_at, input int wls_at,
                            input logic [1:0] wls_new, input int rst_at);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(par_bit);
    bits.push_back(stop1);
    if (nstop == 2) bits.push_back(1'b1);
    frame_t0 = tick_no + 1;
    for (int b = 0; b < bits.size(); b++) begin
      for (int t = 0; t < os; t++) begin
        int k;
        k = b * os + t;
        if (k == rst_at) begin
          rst = 1'b1;
          clk_step(1'b0);
          rst  = 1'b0;
          rx_i = 1'b1;
          return;
        end
        if (k == wls_at) wls = wls_new;
        rx_i = (k == glitch_at) ? ~bits[b] : bits[b];
        tick();
      end
    end
    rx_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; baud_en = 1'b0; rx_i = 1'b1;
    wls = WLS_8; pen = 1'b0; eps = 1'b0; sp = 1'b0; stb = 1'b0; osm_sel = 1'b0;
    repeat (3) clk_step(1'b0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset pe/fe/bi", 32'({pe, fe, bi}), 32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_busy", 32'(rx_busy), 32'd0);
    check("reset state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    idle(4);

    // 8N1, 16x, 0xA5: rx_valid one clock after tick 153 counted from detect.
    expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 16, 1'b0, 1'b0, 1'b1, 1, -1, -1, WLS_8, -1);
    check("8n1 latency ticks", 32'(last_valid_tick - frame_t0), 32'd153);
    check("8n1 valid on tick edge", 32'(last_valid_on_tick), 32'd1);
    idle(4);
    check("8n1 drained", 32'(exp_q.size()), 32'd0);

    // 5E1, 0x15, parity bit 0 (even parity wants 1).
    wls = WLS_5; pen = 1'b1; eps = 1'b1;
    expect_frame(8'h15, model_pe(8'h15, 5, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    send_frame(8'h15, 5, 16, 1'b1, 1'b0, 1'b1, 1, -1, -1, WLS_5, -1);
    idle(4);
    check("5e1 drained", 32'(exp_q.size()), 32'd0);

    // False start: low for 4 ticks; the start-bit vote at tc 7..9 sees high.
    wls = WLS_8; pen = 1'b0; eps = 1'b0;
    rx_i = 1'b0;
    tick();
    check("false start busy at detect", 32'(rx_busy), 32'd1);
    repeat (3) tick();
    rx_i = 1'b1;
    repeat (5) tick();
    check("false start busy before vote", 32'(rx_busy), 32'd1);
    tick();
    check("false start busy after vote", 32'(rx_busy), 32'd0);
    idle(30);
    check("false start no frame", 32'(exp_q.size()), 32'd0);

    // 8N1 0x3C with bit2 inverted for the single tick at tc=8.
    expect_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 16, 1'b0, 1'b0, 1'b1, 1, 3 * 16 + 8, -1, WLS_8, -1);
    idle(4);
    check("glitch drained", 32'(exp_q.size()), 32'd0);

    // Break: line low for two frame times yields exactly one frame.
    expect_frame(8'h00, 1'b0, 1'b1, 1'b1);
    rx_i = 1'b0;
    repeat (320) tick();
    check("break busy while low", 32'(rx_busy), 32'd1);
    check("break wait state", 32'(state_dbg), 32'(ST_BRK_WAIT));
    idle(3);
    check("break idle after release", 32'(rx_busy), 32'd0);
    check("break bi held", 32'({bi, fe}), 32'b11);
    idle(13);
    expect_frame(8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 8, 16, 1'b0, 1'b0, 1'b1, 1, -1, -1, WLS_8, -1);
    idle(4);
    check("post-break drained", 32'(exp_q.size()), 32'd0);

    // 13x, 7 bits, stick parity (bit must be 1), 2 stops, wls changed mid-frame.
    osm_sel = 1'b1; wls = WLS_7; pen = 1'b1; sp = 1'b1; eps = 1'b0; stb = 1'b1;
    expect_frame(8'h41, model_pe(8'h41, 7, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
    send_frame(8'h41, 7, 13, 1'b1, 1'b1, 1'b1, 2, -1, 13 * 3, WLS_5, -1);
    wls = WLS_7;
    idle(4);
    check("stick drained", 32'(exp_q.size()), 32'd0);

    // Same frame with the first stop bit low.
    expect_frame(8'h41, 1'b0, 1'b1, 1'b0);
    send_frame(8'h41, 7, 13, 1'b1, 1'b1, 1'b0, 2, -1, -1, WLS_7, -1);
    idle(4);
    check("stick fe drained", 32'(exp_q.size()), 32'd0);
    check("outputs hold", 32'({bi, fe, pe, rx_data}), 32'({1'b0, 1'b1, 1'b0, 8'h41}));

    // Reset during data bit 3: frame abandoned, published outputs cleared.
    send_frame(8'h41, 7, 13, 1'b1, 1'b1, 1'b1, 2, -1, -1, WLS_7, 13 * 4 + 3);
    check("mid reset rx_data", 32'(rx_data), 32'd0);
    check("mid reset pe/fe/bi", 32'({pe, fe, bi}), 32'd0);
    check("mid reset busy", 32'(rx_busy), 32'd0);
    idle(200);
    check("mid reset no frame", 32'(exp_q.size()), 32'd0);

    // Recovery with the default 8N1 16x format.
    osm_sel = 1'b0; wls = WLS_8; pen = 1'b0; sp = 1'b0; stb = 1'b0;
    expect_frame(8'h81, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 8, 16, 1'b0, 1'b0, 1'b1, 1, -1, -1, WLS_8, -1);
    idle(4);
    check("final drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
